// File: rtl/lcd_timing_pkg.sv
// Shared panel constants for the 480x272 RGB LCD and the types passed between
// the timing generator and its delay line; pixel generators import it too.
package lcd_timing_pkg;

    localparam int unsigned COORD_W     = 11;
    localparam int unsigned FRAME_CNT_W = 16;
    localparam int unsigned MAX_TOTAL   = 2048;

    localparam int unsigned H_ACTIVE_DEF = 480;
    localparam int unsigned H_FP_DEF     = 2;
    localparam int unsigned H_SYNC_DEF   = 41;
    localparam int unsigned H_BP_DEF     = 2;
    localparam int unsigned V_ACTIVE_DEF = 272;
    localparam int unsigned V_FP_DEF     = 2;
    localparam int unsigned V_SYNC_DEF   = 10;
    localparam int unsigned V_BP_DEF     = 2;

    localparam int unsigned H_TOTAL_DEF = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int unsigned V_TOTAL_DEF = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;

    localparam int unsigned LCD_WIDTH  = H_ACTIVE_DEF;
    localparam int unsigned LCD_HEIGHT = V_ACTIVE_DEF;

    localparam logic DEN_INACTIVE   = 1'b0;
    localparam logic HSYNC_INACTIVE = 1'b1;
    localparam logic VSYNC_INACTIVE = 1'b1;

    typedef struct packed {
        logic den;
        logic hsync_n;
        logic vsync_n;
    } lcd_ctrl_t;

    localparam lcd_ctrl_t CTRL_INACTIVE = '{den: DEN_INACTIVE, hsync_n: HSYNC_INACTIVE,
                                            vsync_n: VSYNC_INACTIVE};

    // True when lo <= pos < lo+len.
    function automatic logic in_window(logic [31:0] pos, int unsigned lo, int unsigned len);
        return (pos >= lo) && (pos < lo + len);
    endfunction

endpackage

// File: rtl/lcd_timing_gen_if.sv
// Raster bundle from the timing generator: coordinate/enable stream for pixel
// generators, delayed panel controls, and line/frame pacing strobes.
interface lcd_timing_gen_if;
    import lcd_timing_pkg::*;

    logic                   DEN;
    logic [COORD_W-1:0]     X;
    logic [COORD_W-1:0]     Y;
    logic                   LCD_DEN;
    logic                   LCD_HSYNC;
    logic                   LCD_VSYNC;
    logic                   LINE_START;
    logic                   FRAME_START;
    logic [FRAME_CNT_W-1:0] FRAME_CNT;

    modport master (
        output DEN, X, Y, LCD_DEN, LCD_HSYNC, LCD_VSYNC, LINE_START, FRAME_START, FRAME_CNT
    );

    modport slave (
        input DEN, X, Y, LCD_DEN, LCD_HSYNC, LCD_VSYNC, LINE_START, FRAME_START, FRAME_CNT
    );

endinterface

// File: rtl/lcd_timing_gen_sync_delay_line.sv
// Fixed-depth shift register; reset loads every stage with INIT so the output
// stays at the init value until real data has propagated. DEPTH=0 is a wire.
module sync_delay_line #(
    parameter int unsigned       WIDTH = 1,
    parameter int unsigned       DEPTH = 1,
    parameter logic [WIDTH-1:0]  INIT  = '0
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH == 0) begin : g_wire
        logic unused_clk_rst;
        assign unused_clk_rst = clk_i ^ rst_ni;
        assign q_o = d_i;
    end else begin : g_reg
        logic [WIDTH-1:0] stage_q [DEPTH];

        always_ff @(posedge clk_i) begin
            if (!rst_ni) begin
                for (int i = 0; i < DEPTH; i++) stage_q[i] <= INIT;
            end else begin
                stage_q[0] <= d_i;
                for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
            end
        end

        assign q_o = stage_q[DEPTH-1];
    end

endmodule

// File: rtl/lcd_timing_gen.sv
// Raster timing for the RGB LCD: free-running h/v counters, active-area and
// sync decode, panel controls delayed to match registered colour, frame count.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int unsigned H_ACTIVE   = LCD_WIDTH,
    parameter int unsigned H_FP       = H_FP_DEF,
    parameter int unsigned H_SYNC     = H_SYNC_DEF,
    parameter int unsigned H_BP       = H_BP_DEF,
    parameter int unsigned V_ACTIVE   = LCD_HEIGHT,
    parameter int unsigned V_FP       = V_FP_DEF,
    parameter int unsigned V_SYNC     = V_SYNC_DEF,
    parameter int unsigned V_BP       = V_BP_DEF,
    parameter int unsigned PIPE_DELAY = 1
) (
    input  logic             CLK,
    input  logic             RST_IN,
    lcd_timing_gen_if.master bus
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_TOTAL - 1);
    localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_TOTAL - 1);

    if (H_TOTAL > MAX_TOTAL || V_TOTAL > MAX_TOTAL) begin : g_bad_geometry
        $error("lcd_timing_gen: H_TOTAL=%0d V_TOTAL=%0d exceed %0d", H_TOTAL, V_TOTAL, MAX_TOTAL);
    end

    logic [COORD_W-1:0]     hcnt_q, hcnt_d;
    logic [COORD_W-1:0]     vcnt_q, vcnt_d;
    logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
    logic                   h_last, v_last;
    logic [31:0]            h_pos, v_pos;
    logic                   line_start;
    lcd_ctrl_t              ctrl, ctrl_dly;

    always_comb begin
        h_last      = (hcnt_q == H_LAST);
        v_last      = (vcnt_q == V_LAST);
        hcnt_d      = h_last ? '0 : hcnt_q + 1'b1;
        vcnt_d      = vcnt_q;
        frame_cnt_d = frame_cnt_q;
        if (h_last) begin
            vcnt_d = v_last ? '0 : vcnt_q + 1'b1;
            if (v_last) frame_cnt_d = frame_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_IN) begin
            hcnt_q      <= '0;
            vcnt_q      <= '0;
            frame_cnt_q <= '0;
        end else begin
            hcnt_q      <= hcnt_d;
            vcnt_q      <= vcnt_d;
            frame_cnt_q <= frame_cnt_d;
        end
    end

    // Gated by RST_IN directly so reset silences DEN and strobes in the same clock.
    always_comb begin
        h_pos      = 32'(hcnt_q);
        v_pos      = 32'(vcnt_q);
        ctrl       = CTRL_INACTIVE;
        line_start = 1'b0;
        if (RST_IN) begin
            ctrl.den     = (h_pos < H_ACTIVE) && (v_pos < V_ACTIVE);
            ctrl.hsync_n = !in_window(h_pos, H_ACTIVE + H_FP, H_SYNC);
            ctrl.vsync_n = !in_window(v_pos, V_ACTIVE + V_FP, V_SYNC);
            line_start   = (hcnt_q == '0);
        end
    end

    sync_delay_line #(
        .WIDTH (3),
        .DEPTH (PIPE_DELAY),
        .INIT  (CTRL_INACTIVE)
    ) u_ctrl_dly (
        .clk_i  (CLK),
        .rst_ni (RST_IN),
        .d_i    (ctrl),
        .q_o    (ctrl_dly)
    );

    assign bus.DEN         = ctrl.den;
    assign bus.X           = hcnt_q;
    assign bus.Y           = vcnt_q;
    assign bus.LINE_START  = line_start;
    assign bus.FRAME_START = line_start && (vcnt_q == '0);
    assign bus.FRAME_CNT   = frame_cnt_q;
    assign bus.LCD_DEN     = ctrl_dly.den;
    assign bus.LCD_HSYNC   = ctrl_dly.hsync_n;
    assign bus.LCD_VSYNC   = ctrl_dly.vsync_n;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: five instances (small geometry at delays 1/0/3,
// default panel, tiny 8x4 frame for the counter wrap) against a raster model.
module tb_lcd_timing_gen;
    import lcd_timing_pkg::*;

    localparam int unsigned S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int unsigned S_VA = 4, S_VF = 1, S_VS = 2, S_VB = 1;
    localparam int unsigned W_HA = 4, W_HF = 1, W_HS = 2, W_HB = 1;
    localparam int unsigned W_VA = 1, W_VF = 1, W_VS = 1, W_VB = 1;
    localparam int N_DUT = 5;

    typedef struct packed {
        logic        den;
        logic [10:0] x;
        logic [10:0] y;
        logic        lcd_den;
        logic        lcd_hs;
        logic        lcd_vs;
        logic        ls;
        logic        fs;
        logic [15:0] fc;
    } obs_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic rst_cmd = 1'b0;
    always #5 clk = ~clk;

    // ---------------- DUTs ----------------
    lcd_timing_gen_if if0 ();
    lcd_timing_gen_if if1 ();
    lcd_timing_gen_if if2 ();
    lcd_timing_gen_if if3 ();
    lcd_timing_gen_if if4 ();

    lcd_timing_gen #(.H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
                     .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
                     .PIPE_DELAY(1)) u_dut0 (.CLK(clk), .RST_IN(rst_n), .bus(if0));
    lcd_timing_gen #(.H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
                     .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
                     .PIPE_DELAY(0)) u_dut1 (.CLK(clk), .RST_IN(rst_n), .bus(if1));
    lcd_timing_gen #(.H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
                     .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
                     .PIPE_DELAY(3)) u_dut2 (.CLK(clk), .RST_IN(rst_n), .bus(if2));
    lcd_timing_gen u_dut3 (.CLK(clk), .RST_IN(rst_n), .bus(if3));
    lcd_timing_gen #(.H_ACTIVE(W_HA), .H_FP(W_HF), .H_SYNC(W_HS), .H_BP(W_HB),
                     .V_ACTIVE(W_VA), .V_FP(W_VF), .V_SYNC(W_VS), .V_BP(W_VB),
                     .PIPE_DELAY(1)) u_dut4 (.CLK(clk), .RST_IN(rst_n), .bus(if4));

    obs_t obs [N_DUT];
    assign obs[0] = {if0.DEN, if0.X, if0.Y, if0.LCD_DEN, if0.LCD_HSYNC, if0.LCD_VSYNC,
                     if0.LINE_START, if0.FRAME_START, if0.FRAME_CNT};
    assign obs[1] = {if1.DEN, if1.X, if1.Y, if1.LCD_DEN, if1.LCD_HSYNC, if1.LCD_VSYNC,
                     if1.LINE_START, if1.FRAME_START, if1.FRAME_CNT};
    assign obs[2] = {if2.DEN, if2.X, if2.Y, if2.LCD_DEN, if2.LCD_HSYNC, if2.LCD_VSYNC,
                     if2.LINE_START, if2.FRAME_START, if2.FRAME_CNT};
    assign obs[3] = {if3.DEN, if3.X, if3.Y, if3.LCD_DEN, if3.LCD_HSYNC, if3.LCD_VSYNC,
                     if3.LINE_START, if3.FRAME_START, if3.FRAME_CNT};
    assign obs[4] = {if4.DEN, if4.X, if4.Y, if4.LCD_DEN, if4.LCD_HSYNC, if4.LCD_VSYNC,
                     if4.LINE_START, if4.FRAME_START, if4.FRAME_CNT};

    // ---------------- reference model ----------------
    int unsigned g_ha [N_DUT], g_hf [N_DUT], g_hs [N_DUT], g_hb [N_DUT];
    int unsigned g_va [N_DUT], g_vf [N_DUT], g_vs [N_DUT], g_vb [N_DUT], g_pd [N_DUT];
    int unsigned p;                 // clock edges since the last reset edge
    lcd_ctrl_t   hist [N_DUT][3];   // hist[i][k] = panel controls k+1 clocks ago
    logic [15:0] fc_off [N_DUT];    // frame count offset after a forced load

    function automatic int unsigned h_tot(int i);
        return g_ha[i] + g_hf[i] + g_hs[i] + g_hb[i];
    endfunction

    function automatic int unsigned v_tot(int i);
        return g_va[i] + g_vf[i] + g_vs[i] + g_vb[i];
    endfunction

    function automatic lcd_ctrl_t spec_ctrl(int i, int unsigned x, int unsigned y, bit r);
        lcd_ctrl_t c;
        c.den     = r && (x < g_ha[i]) && (y < g_va[i]);
        c.hsync_n = !(r && (x >= g_ha[i] + g_hf[i]) && (x < g_ha[i] + g_hf[i] + g_hs[i]));
        c.vsync_n = !(r && (y >= g_va[i] + g_vf[i]) && (y < g_va[i] + g_vf[i] + g_vs[i]));
        return c;
    endfunction

    function automatic obs_t model(int i, bit r);
        obs_t        e;
        lcd_ctrl_t   c, l;
        int unsigned x, y;
        x      = p % h_tot(i);
        y      = (p / h_tot(i)) % v_tot(i);
        c      = spec_ctrl(i, x, y, r);
        l      = (g_pd[i] == 0) ? c : hist[i][g_pd[i]-1];
        e.den  = c.den;
        e.x    = 11'(x);
        e.y    = 11'(y);
        e.lcd_den = l.den;
        e.lcd_hs  = l.hsync_n;
        e.lcd_vs  = l.vsync_n;
        e.ls   = r && (x == 0);
        e.fs   = r && (x == 0) && (y == 0);
        e.fc   = 16'(p / (h_tot(i) * v_tot(i))) + fc_off[i];
        return e;
    endfunction

    task automatic model_edge();
        if (!rst_n) begin
            p = 0;
            for (int i = 0; i < N_DUT; i++) begin
                fc_off[i] = '0;
                for (int k = 0; k < 3; k++) hist[i][k] = CTRL_INACTIVE;
            end
        end else begin
            for (int i = 0; i < N_DUT; i++) begin
                hist[i][2] = hist[i][1];
                hist[i][1] = hist[i][0];
                hist[i][0] = spec_ctrl(i, p % h_tot(i), (p / h_tot(i)) % v_tot(i), 1'b1);
            end
            p++;
        end
    endtask

    // ---------------- scoreboard ----------------
    int n_vec = 0;
    int n_err = 0;
    logic [31:0] exp_q [$];

    task automatic check_eq(string tag, logic [31:0] got, logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s got=%0h want=%0h at %0t", tag, got, want, $time);
        end
    endtask

    task automatic check_all();
        obs_t e;
        for (int i = 0; i < N_DUT; i++) begin
            e = model(i, rst_n);
            check_eq($sformatf("i%0d_den", i),     32'(obs[i].den),     32'(e.den));
            check_eq($sformatf("i%0d_x", i),       32'(obs[i].x),       32'(e.x));
            check_eq($sformatf("i%0d_y", i),       32'(obs[i].y),       32'(e.y));
            check_eq($sformatf("i%0d_lcd_den", i), 32'(obs[i].lcd_den), 32'(e.lcd_den));
            check_eq($sformatf("i%0d_lcd_hs", i),  32'(obs[i].lcd_hs),  32'(e.lcd_hs));
            check_eq($sformatf("i%0d_lcd_vs", i),  32'(obs[i].lcd_vs),  32'(e.lcd_vs));
            check_eq($sformatf("i%0d_line_st", i), 32'(obs[i].ls),      32'(e.ls));
            check_eq($sformatf("i%0d_frame_st", i),32'(obs[i].fs),      32'(e.fs));
            check_eq($sformatf("i%0d_frame_cnt", i),32'(obs[i].fc),     32'(e.fc));
        end
    endtask

    // ---------------- driver tasks ----------------
    // Inputs change 1ns after the rising edge; outputs are checked on the falling edge.
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1 rst_n = rst_cmd;
        @(negedge clk);
        check_all();
    endtask

    task automatic do_reset(int n);
        rst_cmd = 1'b0;
        repeat (n) tick();
        rst_cmd = 1'b1;
    endtask

    // ---------------- main sequence ----------------
    int unsigned den_cnt, hs_cnt, hs_first_x;
    bit          hs_seen, wrap_seen;
    logic [15:0] prev_fc;

    initial begin
        g_ha = '{S_HA, S_HA, S_HA, H_ACTIVE_DEF, W_HA};
        g_hf = '{S_HF, S_HF, S_HF, H_FP_DEF,     W_HF};
        g_hs = '{S_HS, S_HS, S_HS, H_SYNC_DEF,   W_HS};
        g_hb = '{S_HB, S_HB, S_HB, H_BP_DEF,     W_HB};
        g_va = '{S_VA, S_VA, S_VA, V_ACTIVE_DEF, W_VA};
        g_vf = '{S_VF, S_VF, S_VF, V_FP_DEF,     W_VF};
        g_vs = '{S_VS, S_VS, S_VS, V_SYNC_DEF,   W_VS};
        g_vb = '{S_VB, S_VB, S_VB, V_BP_DEF,     W_VB};
        g_pd = '{1, 0, 3, 1, 1};
        p = 0;
        for (int i = 0; i < N_DUT; i++) begin
            fc_off[i] = '0;
            for (int k = 0; k < 3; k++) hist[i][k] = CTRL_INACTIVE;
        end

        // Reset hold, release, then one default-panel line plus a few small frames.
        do_reset(5);
        exp_q.push_back(32'd0);
        exp_q.push_back(32'(H_TOTAL_DEF));
        den_cnt = 0; hs_cnt = 0; hs_first_x = 0; hs_seen = 0;
        for (int t = 0; t < 600; t++) begin
            tick();
            if (t == 0) begin
                check_eq("rel_den", 32'(obs[0].den), 32'd1);
                check_eq("rel_frame_st", 32'(obs[0].fs), 32'd1);
                check_eq("rel_lcd_den", 32'(obs[0].lcd_den), 32'd0);
            end
            if (t == 1) check_eq("rel_lcd_den_next", 32'(obs[0].lcd_den), 32'd1);
            if (t < 525 && obs[3].den) den_cnt++;
            if (t >= 1 && t <= 525 && !obs[3].lcd_hs) begin
                hs_cnt++;
                if (!hs_seen) begin
                    hs_seen    = 1'b1;
                    hs_first_x = 32'(obs[3].x);
                end
            end
            if (obs[3].ls) begin
                if (exp_q.size() == 0) check_eq("line_start_extra", 32'(t), 32'hFFFF_FFFF);
                else check_eq("line_start_time", 32'(t), exp_q.pop_front());
            end
        end
        check_eq("line_starts_left", 32'(exp_q.size()), 32'd0);
        check_eq("line_den_clocks", den_cnt, 32'(H_ACTIVE_DEF));
        check_eq("line_hsync_clocks", hs_cnt, 32'(H_SYNC_DEF));
        check_eq("line_hsync_first_x", hs_first_x, 32'(H_ACTIVE_DEF + H_FP_DEF + 1));

        // Random run lengths with short mid-frame resets.
        for (int seg = 0; seg < 6; seg++) begin
            repeat ($urandom_range(400, 100)) tick();
            do_reset(int'($urandom_range(3, 1)));
        end
        repeat ($urandom_range(200, 50)) tick();

        // Load FRAME_CNT with 0xFFFF on the tiny-frame instance and watch it wrap.
        for (int k = 0; k < 64 && (p % (h_tot(4) * v_tot(4))) != 0; k++) tick();
        check_eq("force_align", 32'(p % (h_tot(4) * v_tot(4))), 32'd0);
        force u_dut4.frame_cnt_q = 16'hFFFF;
        fc_off[4] = 16'hFFFF - 16'(p / (h_tot(4) * v_tot(4)));
        @(posedge clk);
        model_edge();
        #1;
        rst_n = rst_cmd;
        release u_dut4.frame_cnt_q;
        @(negedge clk);
        check_all();
        check_eq("forced_cnt", 32'(obs[4].fc), 32'hFFFF);
        wrap_seen = 1'b0;
        prev_fc   = obs[4].fc;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (prev_fc == 16'hFFFF && obs[4].fc != 16'hFFFF) begin
                wrap_seen = 1'b1;
                check_eq("wrap_value", 32'(obs[4].fc), 32'd0);
                check_eq("wrap_x", 32'(obs[4].x), 32'd0);
                check_eq("wrap_frame_st", 32'(obs[4].fs), 32'd1);
            end
            prev_fc = obs[4].fc;
        end
        check_eq("wrap_seen", 32'(wrap_seen), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/lcd_timing_gen.md
Name: lcd_timing_gen

Overview:
- Drives the panel-side raster timing for the 480x272 RGB LCD.
- Produces the pixel coordinate and data-enable stream (DEN, X, Y) consumed by pixel generators such as the pong renderer.
- Produces the panel control signals LCD_DEN, LCD_HSYNC and LCD_VSYNC. These are delayed to line up with the generator's registered colour output.
- Also emits frame and line strobes plus a frame counter for game-tick pacing.

Parameters:
H_ACTIVE, 480, visible pixels per line
H_FP, 2, horizontal front porch (clocks)
H_SYNC, 41, HSYNC low width (clocks)
H_BP, 2, horizontal back porch (clocks)
V_ACTIVE, 272, visible lines per frame
V_FP, 2, vertical front porch (lines)
V_SYNC, 10, VSYNC low width (lines)
V_BP, 2, vertical back porch (lines)
PIPE_DELAY, 1, clocks of delay on LCD_* outputs relative to DEN/X/Y (0 = no delay)

Ports:
CLK  in  1  pixel clock; everything advances on its rising edge
RST_IN  in  1  reset, synchronous, active-low
DEN  out  1  high when (X,Y) is inside the active area
X  out  11  horizontal counter (hcnt)
Y  out  11  vertical counter (vcnt)
LCD_DEN  out  1  DEN delayed PIPE_DELAY clocks, to panel
LCD_HSYNC  out  1  active-low hsync delayed PIPE_DELAY clocks, to panel
LCD_VSYNC  out  1  active-low vsync delayed PIPE_DELAY clocks, to panel
LINE_START  out  1  one-clock pulse when hcnt==0
FRAME_START  out  1  one-clock pulse when hcnt==0 and vcnt==0
FRAME_CNT  out  16  completed-frame count, wraps modulo 2^16

Behaviour:
- Totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (default 525). V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (default 286). Both must be ≤2048; elaboration error otherwise.
- Line order: active, then front porch, then sync, then back porch.
- hcnt increments every clock.
  - At hcnt==H_TOTAL-1: hcnt←0 and vcnt advances.
  - At vcnt==V_TOTAL-1 together with hcnt==H_TOTAL-1: vcnt←0 and FRAME_CNT←FRAME_CNT+1 (wraps 0xFFFF→0).
- X=hcnt and Y=vcnt at all times, including blanking. Pixel generators must qualify with DEN.
- DEN = (hcnt<H_ACTIVE) && (vcnt<V_ACTIVE). It is decoded from the counter registers with no added latency.
- Internal hsync_n = 0 when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC (default 482..522).
- Internal vsync_n = 0 when V_ACTIVE+V_FP ≤ vcnt < V_ACTIVE+V_FP+V_SYNC (default 274..283), for every clock of those lines.
- LCD_DEN, LCD_HSYNC and LCD_VSYNC are the values of DEN, hsync_n and vsync_n from PIPE_DELAY clocks earlier, through a shift register. Default 1 matches a generator that registers colour one clock after sampling X/Y.
- LINE_START and FRAME_START are decoded from the counters. They are coincident with X=0, not delayed.
- Reset, checked every clock while RST_IN==0, overriding everything:
  - hcnt=vcnt=0, FRAME_CNT=0.
  - DEN, LINE_START and FRAME_START forced 0.
  - Every delay stage loaded with the inactive values: DEN 0, HSYNC 1, VSYNC 1.
  - LCD_DEN=0, LCD_HSYNC=1, LCD_VSYNC=1.
- Reset release: the first clock with RST_IN==1 presents X=0, Y=0, DEN=1, LINE_START=1, FRAME_START=1.
  - FRAME_CNT does not increment on that start; it counts wraps only.
  - LCD_* outputs show reset-inactive values until the first real value emerges, after PIPE_DELAY clocks.
- Reset mid-frame: abandons the frame with no partial sync completion. The next frame starts cleanly at (0,0).
- Wrap boundary: the clock after (H_TOTAL-1, V_TOTAL-1) presents (0,0) with both strobes high. There are no skipped or duplicated counts.

Decomposition:
- Shared package lcd_timing_pkg holds:
  - the default panel constants (H_*/V_* values, H_TOTAL, V_TOTAL);
  - the coordinate width 11;
  - the inactive sync polarity constants.
- lcd_pong and later pixel generators import the same package for LCD_WIDTH/LCD_HEIGHT.
- One sub-module, sync_delay_line:
  - parameters WIDTH and DEPTH, plus an init value;
  - synchronous active-low reset to that init value;
  - DEPTH=0 is a wire.
  - Instantiated once, 3 bits wide, for {DEN, hsync_n, vsync_n}.

Test Plan:
- Reset hold 5 clocks, then release → during reset LCD_DEN=0, LCD_HSYNC=1, LCD_VSYNC=1, X=Y=0, FRAME_CNT=0. The first clock after release gives X=0, Y=0, DEN=1, FRAME_START=1, and LCD_DEN=1 one clock later.
- Run one line (defaults) → DEN high exactly 480 clocks (X 0..479); HSYNC low exactly 41 clocks starting at X=482; LINE_START period 525 clocks.
- Run one full frame → 272 lines with any DEN; VSYNC low for lines 274..283 (10×525 clocks); FRAME_START period 525×286=150150 clocks; FRAME_CNT 0→1 exactly at the (524,285)→(0,0) wrap.
- Alignment check → on every clock, LCD_DEN/LCD_HSYNC/LCD_VSYNC equal the DEN/hsync_n/vsync_n of the previous clock. Repeat with PIPE_DELAY=0 (identical same clock) and PIPE_DELAY=3.
- Assert reset at X=300, Y=150 for 2 clocks → outputs go inactive on the next edge. After release, counting restarts at (0,0) and FRAME_CNT=0.
- Force FRAME_CNT to 0xFFFF (run with small V_TOTAL=4, H_TOTAL=8 overrides) → it wraps to 0 with no glitch on the strobes.
